// File: rtl/udp_stream_packetizer.sv
// Slices an unframed AXI-Stream into fixed PKT_WORDS packets, padding stalled packets after a timeout.
// Optional `PACKETIZER_SEQ_HDR_EN prepends a 32-bit big-endian sequence number to every packet.
module udp_stream_packetizer #(
    parameter int          WORD_BYTES     = 1,
    parameter int          PKT_WORDS      = 64,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [WORD_BYTES*8-1:0]   s_axis_tdata_i,
    input  logic                      s_axis_tvalid_i,
    output logic                      s_axis_tready_o,
    output logic [WORD_BYTES*8-1:0]   m_axis_tdata_o,
    output logic                      m_axis_tvalid_o,
    output logic                      m_axis_tlast_o,
    output logic [11:0]               m_axis_tuser_o,
    input  logic                      m_axis_tready_i,
    output logic [15:0]               pkt_count_o,
    output logic [15:0]               pad_count_o
);
    localparam int W       = WORD_BYTES * 8;
    localparam int CW      = $clog2(PKT_WORDS + 1);
    localparam int IW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LAST_IDX = CW'(PKT_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
`ifdef PACKETIZER_SEQ_HDR_EN
        S_PAD,
        S_HDR
`else
        S_PAD
`endif
    } state_t;

    state_t          state;
    logic [CW-1:0]   word_cnt;
    logic [IW-1:0]   idle_cnt;
    logic            adv;
    logic            accept;
    logic            idle_tick;
    logic            last_word;

    assign m_axis_tuser_o = 12'(PKT_WORDS);
    assign adv            = !m_axis_tvalid_o || m_axis_tready_i;
    assign last_word      = (word_cnt == LAST_IDX);

`ifdef PACKETIZER_SEQ_HDR_EN
    localparam int HDR_WORDS = 4 / WORD_BYTES;
    localparam logic [CW-1:0] HDR_LAST = CW'(HDR_WORDS - 1);
    logic [31:0]   seq_q;
    logic [31:0]   hdr_shift;
    logic [W-1:0]  hdr_word;
    // Header words leave MSB-first; word_cnt doubles as the header word index.
    assign hdr_shift = seq_q << (W * int'(word_cnt));
    assign hdr_word  = hdr_shift[31 -: W];
    // In IDLE the pending beat only triggers the header; it is taken later in FILL.
    assign s_axis_tready_o = !rst_i && adv && (state == S_FILL);
`else
    assign s_axis_tready_o = !rst_i && adv && (state == S_IDLE || state == S_FILL);
`endif

    assign accept    = s_axis_tvalid_i && s_axis_tready_o;
    assign idle_tick = s_axis_tready_o && !s_axis_tvalid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            word_cnt        <= '0;
            idle_cnt        <= '0;
            m_axis_tdata_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
            m_axis_tlast_o  <= 1'b0;
            pkt_count_o     <= '0;
            pad_count_o     <= '0;
`ifdef PACKETIZER_SEQ_HDR_EN
            seq_q           <= '0;
`endif
        end else begin
            // Slice drains by default; any load below overrides this.
            if (m_axis_tvalid_o && m_axis_tready_i)
                m_axis_tvalid_o <= 1'b0;

            case (state)
                S_IDLE: begin
`ifdef PACKETIZER_SEQ_HDR_EN
                    if (s_axis_tvalid_i) begin
                        word_cnt <= '0;
                        state    <= S_HDR;
                    end
`else
                    if (accept) begin
                        m_axis_tdata_o  <= s_axis_tdata_i;
                        m_axis_tvalid_o <= 1'b1;
                        idle_cnt        <= '0;
                        if (PKT_WORDS == 1) begin
                            m_axis_tlast_o <= 1'b1;
                            word_cnt       <= '0;
                            pkt_count_o    <= pkt_count_o + 16'd1;
                        end else begin
                            m_axis_tlast_o <= 1'b0;
                            word_cnt       <= CW'(1);
                            state          <= S_FILL;
                        end
                    end
`endif
                end
                S_FILL: begin
                    if (accept) begin
                        m_axis_tdata_o  <= s_axis_tdata_i;
                        m_axis_tvalid_o <= 1'b1;
                        m_axis_tlast_o  <= last_word;
                        idle_cnt        <= '0;
                        if (last_word) begin
                            word_cnt    <= '0;
                            pkt_count_o <= pkt_count_o + 16'd1;
`ifdef PACKETIZER_SEQ_HDR_EN
                            seq_q       <= seq_q + 32'd1;
`endif
                            state       <= S_IDLE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end else if (TIMEOUT_CYCLES != 0 && idle_tick) begin
                        if (idle_cnt == IW'(TO_LAST)) begin
                            idle_cnt    <= '0;
                            pad_count_o <= pad_count_o + 16'd1;
                            state       <= S_PAD;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (adv) begin
                        m_axis_tdata_o  <= {WORD_BYTES{PAD_BYTE}};
                        m_axis_tvalid_o <= 1'b1;
                        m_axis_tlast_o  <= last_word;
                        if (last_word) begin
                            word_cnt    <= '0;
                            pkt_count_o <= pkt_count_o + 16'd1;
`ifdef PACKETIZER_SEQ_HDR_EN
                            seq_q       <= seq_q + 32'd1;
`endif
                            state       <= S_IDLE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
`ifdef PACKETIZER_SEQ_HDR_EN
                S_HDR: begin
                    if (adv) begin
                        m_axis_tdata_o  <= hdr_word;
                        m_axis_tvalid_o <= 1'b1;
                        m_axis_tlast_o  <= 1'b0;
                        word_cnt        <= word_cnt + 1'b1;
                        idle_cnt        <= '0;
                        if (word_cnt == HDR_LAST)
                            state <= S_FILL;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_stream_packetizer.sv
// Bench for udp_stream_packetizer: table-driven framing, timeout padding, random backpressure, async reset.
module tb_udp_stream_packetizer;
    localparam int PKT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [11:0] m_tuser;
    logic        m_tready;
    logic [15:0] pkt_count;
    logic [15:0] pad_count;
    logic        rnd_en;

    udp_stream_packetizer #(
        .WORD_BYTES(1), .PKT_WORDS(PKT), .TIMEOUT_CYCLES(16), .PAD_BYTE(8'h00)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready),
        .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tlast_o(m_tlast),
        .m_axis_tuser_o(m_tuser), .m_axis_tready_i(m_tready),
        .pkt_count_o(pkt_count), .pad_count_o(pad_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic l; } exp_t;
    typedef struct { logic [7:0] din; logic exp_last; } vec_t;

    exp_t        q[$];
    int          pos = 0;
    logic [31:0] seq = 0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference framing: position within packet decides tlast; optional header on packet start.
    task automatic push_model(input logic [7:0] d);
`ifdef PACKETIZER_SEQ_HDR_EN
        if (pos == 0) begin
            for (int k = 0; k < 4; k++) q.push_back('{d: 8'(seq >> (24 - 8*k)), l: 1'b0});
            pos = 4;
        end
`endif
        q.push_back('{d: d, l: (pos == PKT-1)});
        if (pos == PKT-1) begin
            pos = 0;
            seq = seq + 1;
        end else pos++;
    endtask

    task automatic push_pads();
        while (pos != 0) push_model(8'h00);
    endtask

    task automatic send(input logic [7:0] d);
        int waited = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!s_tready) begin
            n_total++;
            $display("FAIL send_timeout: byte 0x%0h not accepted within 200 cycles", d);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_m(input logic [7:0] d);
        push_model(d);
        send(d);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || m_tvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic monitor();
        logic       stalled = 1'b0;
        logic [7:0] pd = '0;
        logic       pl = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) stalled = 1'b0;
            else begin
                if (stalled) begin
                    chk("stall_valid", m_tvalid, 1);
                    chk("stall_data", m_tdata, pd);
                    chk("stall_last", m_tlast, pl);
                end
                if (m_tvalid) chk("tuser", m_tuser, PKT);
                if (m_tvalid && m_tready) begin
                    if (q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no output", m_tdata);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", m_tdata, e.d);
                        chk("out_last", m_tlast, e.l);
                    end
                end
                stalled = m_tvalid && !m_tready;
                pd = m_tdata;
                pl = m_tlast;
            end
        end
    endtask

    task automatic rdy_gen();
        forever begin
            @(posedge clk); #1;
            if (rnd_en) m_tready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_tvalid"}, m_tvalid, 0);
        chk({tag, "_tlast"}, m_tlast, 0);
        chk({tag, "_tdata"}, m_tdata, 0);
        chk({tag, "_s_tready"}, s_tready, 0);
        chk({tag, "_tuser"}, m_tuser, PKT);
        chk({tag, "_pkt_count"}, pkt_count, 0);
        chk({tag, "_pad_count"}, pad_count, 0);
    endtask

    initial begin
        vec_t tbl [16];
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1; rnd_en = 1'b0;
        fork
            monitor();
            rdy_gen();
        join_none
        #3;
        reset_checks("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

`ifdef PACKETIZER_SEQ_HDR_EN
        for (int i = 0; i < 8; i++) send_m(8'(8'h10 + i));
        drain();
        chk("hdr_pkt_count", pkt_count, 2);
        chk("hdr_pad_count", pad_count, 0);
`else
        // Back-to-back 0x00..0x0F: two packets, tlast on 0x07 and 0x0F.
        for (int i = 0; i < 16; i++) begin
            tbl[i].din      = 8'(i);
            tbl[i].exp_last = (i == 7 || i == 15);
        end
        for (int i = 0; i < 16; i++) begin
            q.push_back('{d: tbl[i].din, l: tbl[i].exp_last});
            send(tbl[i].din);
        end
        drain();
        chk("t1_pkt_count", pkt_count, 2);
        chk("t1_pad_count", pad_count, 0);

        // Three bytes then silence: 15 idle cycles no pad, 16th starts padding.
        send_m(8'hA1); send_m(8'hA2); send_m(8'hA3);
        repeat (15) @(posedge clk);
        #1 chk("t2_no_pad_at_15", pad_count, 0);
        @(posedge clk); #1;
        chk("t2_pad_at_16", pad_count, 1);
        push_pads();
        drain();
        chk("t2_pkt_count", pkt_count, 3);

        // 15-cycle gap is just short of the timeout: one full data packet.
        send_m(8'hB0); send_m(8'hB1); send_m(8'hB2);
        repeat (15) @(posedge clk);
        #1;
        for (int i = 3; i < 8; i++) send_m(8'(8'hB0 + i));
        drain();
        chk("t3_pad_count", pad_count, 1);
        chk("t3_pkt_count", pkt_count, 4);

        // Random downstream backpressure over 40 bytes.
        rnd_en = 1'b1;
        for (int i = 0; i < 40; i++) send_m(8'(i));
        rnd_en = 1'b0;
        m_tready = 1'b1;
        drain();
        chk("t4_pkt_count", pkt_count, 9);
        chk("t4_pad_count", pad_count, 1);

        // Async reset mid-packet: outputs clear without a clock edge.
        for (int i = 0; i < 4; i++) send_m(8'(8'hC0 + i));
        #2;
        chk("t5_valid_before_reset", m_tvalid, 1);
        rst = 1'b1;
        #1;
        reset_checks("t5_async");
        q.delete();
        pos = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send_m(8'(8'hD0 + i));
        drain();
        chk("t5_pkt_count", pkt_count, 1);
        chk("t5_pad_count", pad_count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
